// File: rtl/dmem_sized.sv
// Byte-addressed, word-organised single-port data memory with sized loads/stores.
// A hardware sweep clears the array after reset; responses come back through a two-register pipeline.
module dmem_sized #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  logic [0:0]       state;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             err;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic             clear_we;

  assign req_ready = (state == ST_READY);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[ADDR_W-1:2];
  assign off       = req_addr[1:0];
  assign clear_we  = (state == ST_CLEAR);

  always_comb begin
    err = 1'b0;
    case (req_size)
      2'b00:   err = 1'b0;
      2'b01:   err = off[0];
      2'b10:   err = (off != 2'b00);
      default: err = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the lane enables alone pick the bytes.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        lane_en   = 4'b0001 << off;
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = 4'b0011 << off;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    if (!accept || !req_we || err) lane_en = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem[idx][l*8 +: 8] <= lane_data[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == {IDX_W{1'b1}}) state <= ST_READY;
    end
  end

  // First stage captures the raw word and access shape on the accepting edge.
  logic        p_valid;
  logic        p_err;
  logic        p_load;
  logic [1:0]  p_size;
  logic        p_uns;
  logic [1:0]  p_off;
  logic [31:0] p_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_err   <= 1'b0;
      p_load  <= 1'b0;
      p_size  <= 2'b00;
      p_uns   <= 1'b0;
      p_off   <= 2'b00;
      p_word  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_err  <= err;
        p_load <= !req_we && !err;
        p_size <= req_size;
        p_uns  <= req_unsigned;
        p_off  <= off;
        p_word <= mem[idx];
      end
    end
  end

  logic [31:0] shifted;
  logic [31:0] ext;

  assign shifted = p_word >> {p_off, 3'b000};

  always_comb begin
    ext = p_word;
    case (p_size)
      2'b00:   ext = p_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = p_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = p_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= p_valid;
      if (p_valid) begin
        rsp_err   <= p_err;
        rsp_rdata <= p_load ? ext : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed-vector bench for dmem_sized: clear sweep, sized loads/stores, errors,
// back-to-back traffic and reset in the middle of a transaction.
module tb_dmem_sized;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int n_vec;
  int n_bad;

  dmem_sized #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // One request, checked: response must not appear after the accept edge, only after the next.
  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, size, uns, addr, wdata);
    @(posedge clk); #1;
    idle();
    check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  // Called right after rst_n is released on a falling edge.
  task automatic count_clear(input string tag);
    int edges;
    edges = 0;
    check({tag, "_ready0"}, {31'd0, req_ready}, 32'd0);
    while (edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (req_ready) break;
    end
    check({tag, "_edges"}, edges, 32'd16);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle();
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);

    // 1. clear sweep
    @(negedge clk);
    rst_n = 1'b1;
    count_clear("clr1");
    txn("lw3c", 1'b0, 2'b10, 1'b0, 6'h3C, 32'd0, 32'h0000_0000, 1'b0);

    // 2. sized loads
    txn("sw08", 1'b1, 2'b10, 1'b0, 6'h08, 32'h80FF_7F01, 32'd0, 1'b0);
    txn("lb08", 1'b0, 2'b00, 1'b0, 6'h08, 32'd0, 32'h0000_0001, 1'b0);
    txn("lb0b", 1'b0, 2'b00, 1'b0, 6'h0B, 32'd0, 32'hFFFF_FF80, 1'b0);
    txn("lbu0b", 1'b0, 2'b00, 1'b1, 6'h0B, 32'd0, 32'h0000_0080, 1'b0);
    txn("lh0a", 1'b0, 2'b01, 1'b0, 6'h0A, 32'd0, 32'hFFFF_80FF, 1'b0);
    txn("lhu0a", 1'b0, 2'b01, 1'b1, 6'h0A, 32'd0, 32'h0000_80FF, 1'b0);
    txn("lw_uns", 1'b0, 2'b10, 1'b1, 6'h08, 32'd0, 32'h80FF_7F01, 1'b0);

    // 3. lane writes
    txn("sb09", 1'b1, 2'b00, 1'b0, 6'h09, 32'hFFFF_FFAB, 32'd0, 1'b0);
    txn("lw08a", 1'b0, 2'b10, 1'b0, 6'h08, 32'd0, 32'h80FF_AB01, 1'b0);
    txn("sh0a", 1'b1, 2'b01, 1'b0, 6'h0A, 32'hFFFF_1234, 32'd0, 1'b0);
    txn("lw08b", 1'b0, 2'b10, 1'b0, 6'h08, 32'd0, 32'h1234_AB01, 1'b0);

    // 4. misaligned / illegal
    txn("sw04", 1'b1, 2'b10, 1'b0, 6'h04, 32'hCAFE_F00D, 32'd0, 1'b0);
    txn("sw06_err", 1'b1, 2'b10, 1'b0, 6'h06, 32'hDEAD_BEEF, 32'd0, 1'b1);
    txn("lw04", 1'b0, 2'b10, 1'b0, 6'h04, 32'd0, 32'hCAFE_F00D, 1'b0);
    txn("lh05_err", 1'b0, 2'b01, 1'b0, 6'h05, 32'd0, 32'd0, 1'b1);
    txn("sz3_err", 1'b0, 2'b11, 1'b0, 6'h00, 32'd0, 32'd0, 1'b1);
    txn("sh05_err", 1'b1, 2'b01, 1'b0, 6'h05, 32'hFFFF_FFFF, 32'd0, 1'b1);
    txn("lw04b", 1'b0, 2'b10, 1'b0, 6'h04, 32'd0, 32'hCAFE_F00D, 1'b0);

    // 5. back-to-back store then load, no bubbles
    drive(1'b1, 2'b10, 1'b0, 6'h10, 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 6'h10, 32'd0);
    @(posedge clk); #1;
    idle();
    check("b2b_st_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_st_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("b2b_ld_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_ld_rdata", rsp_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    check("b2b_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("b2b_hold_rdata", rsp_rdata, 32'h1234_5678);

    // 6. reset with a load in flight
    txn("sw20", 1'b1, 2'b10, 1'b0, 6'h20, 32'hFFFF_FFFF, 32'd0, 1'b0);
    drive(1'b0, 2'b10, 1'b0, 6'h20, 32'd0);
    @(posedge clk); #1;
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("mid_valid_edge", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_clear("clr2");
    txn("lw20", 1'b0, 2'b10, 1'b0, 6'h20, 32'd0, 32'h0000_0000, 1'b0);
    txn("lw08c", 1'b0, 2'b10, 1'b0, 6'h08, 32'd0, 32'h0000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the pipelined CPU's MEM stage: byte-addressed, word-organised, single port. Supports byte, half and word loads and stores with sign or zero extension and byte-lane writes. Flags misaligned or illegal-size accesses instead of performing them. After reset it clears itself with a hardware sweep, uses a valid/ready request handshake, and returns a registered one-cycle response.

## Interface
- `ADDR_W`, default 6: byte-address width. Word count DEPTH = 2^(ADDR_W-2). Minimum 3.
- Data width is fixed at 32 bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle pulse per accepted request.
- `rsp_rdata` out 32: load result, extended to 32 bits. 0 for stores and for errors.
- `rsp_err` out 1: accepted request was misaligned or illegal; no effect on memory.

## Operation
- **States.** Two states, CLEAR and READY. A clear counter `clr_idx` is ADDR_W-2 bits wide.
- **CLEAR.**
  - Entered asynchronously whenever `rst_n` = 0, with `clr_idx` = 0.
  - On each rising edge with `rst_n` = 1, write 0 to word `clr_idx`, then increment.
  - After writing word DEPTH-1, go to READY.
  - `req_ready` = 0 throughout; requests are ignored.
- **READY.** `req_ready` = 1. A request is accepted when `req_valid` and `req_ready` are both 1.
- **Word index and byte offset.** Word index = `req_addr[ADDR_W-1:2]`. Byte offset = `req_addr[1:0]`.
- **Error check.** An accepted request is an error if:
  - size is 11, or
  - size is half and offset[0] = 1, or
  - size is word and offset ≠ 0.
- **Error response.** No write. `rsp_err` = 1 and `rsp_rdata` = 0 on the next cycle.
- **Store, byte.** Writes lane = offset with `req_wdata[7:0]`. Other lanes are unchanged.
- **Store, half.** Writes lanes offset and offset+1 with `req_wdata[15:0]`, little-endian.
- **Store, word.** Writes all four lanes.
- **Load.**
  - Extract the byte or half at the offset, little-endian. Extend per `req_unsigned` and `req_size`.
  - Word loads ignore `req_unsigned`.
  - Register the result into `rsp_rdata`.
- **Response.** `rsp_valid` = 1 on the cycle after every accepted request (load, store or error), otherwise 0. `rsp_err` is 0 on good responses.
- **Non-accept cycles.** When no request is accepted, `rsp_rdata` and `rsp_err` hold their values.
- **Memory array.**
  - Written only on clock edges (clear writes or good stores).
  - No reset on the array itself; contents are defined only through the clear sweep.

## Timing
- **Reset values.** While `rst_n` = 0 and asynchronously on assertion: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- **Clear duration.** Exactly DEPTH rising edges after `rst_n` deasserts. `req_ready` rises after the DEPTH-th edge.
- **Latency.** Load latency is 1: request accepted on edge N, result visible after edge N+1. Throughput is one request per cycle with no bubbles.
- **Store-to-load ordering.** A store accepted on edge N updates the array on edge N. A load accepted on edge N+1 to the same word sees the new data.
- **Reset mid-operation.**
  - Any response in flight is dropped; no `rsp_valid` is produced.
  - A store on the same edge as reset assertion is not guaranteed.
  - The clear sweep restarts from word 0.
- **Address range.** No out-of-range condition: every ADDR_W address maps to a word.

## Test plan
All scenarios use ADDR_W = 6, so DEPTH = 16.
1. **Reset and clear.** Release `rst_n` → `req_ready` stays 0 for exactly 16 edges, then 1. lw 0x3C → `rsp_rdata` 0x00000000, `rsp_err` 0.
2. **Sized loads.** sw 0x80FF7F01 @0x08, then:
   - lb 0x08 → 0x00000001
   - lb 0x0B → 0xFFFFFF80
   - lbu 0x0B → 0x00000080
   - lh 0x0A → 0xFFFF80FF
   - lhu 0x0A → 0x000080FF
3. **Lane writes.** Following scenario 2:
   - sb 0x000000AB @0x09, then lw 0x08 → 0x80FFAB01.
   - sh 0x00001234 @0x0A, then lw 0x08 → 0x1234AB01.
4. **Misaligned and illegal.**
   - sw 0xDEADBEEF @0x06 → `rsp_err` 1, `rsp_rdata` 0; lw 0x04 still returns its prior value.
   - lh 0x05 → `rsp_err` 1.
   - size 11 @0x00 → `rsp_err` 1.
5. **Back-to-back.** sw 0x12345678 @0x10 on edge N, lw 0x10 on edge N+1 → `rsp_valid` high after edges N+1 and N+2 with no gap. Load result 0x12345678.
6. **Mid-operation reset.** Store 0xFFFFFFFF @0x20, issue lw 0x20, drop `rst_n` before the response edge → `rsp_valid` 0 immediately. After re-clear (16 edges), lw 0x20 → 0x00000000.
